// File: rtl/broadcast_n.sv
// N-way stream broadcaster: every accepted beat is copied into a small FIFO per
// enabled output; the output-enable mask is latched on the first beat of each frame.
module broadcast_n #(
    parameter int W_DATA = 8,
    parameter int N_OUT  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic [W_DATA-1:0]         din_data,
    input  logic [1:0]                din_eot,
    input  logic [N_OUT-1:0]          dout_en,
    output logic [N_OUT-1:0]          dout_valid,
    input  logic [N_OUT-1:0]          dout_ready,
    output logic [N_OUT*W_DATA-1:0]   dout_data,
    output logic [2*N_OUT-1:0]        dout_eot,
    output logic                      busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t           state;
    logic [N_OUT-1:0] mask_q;
    logic [N_OUT-1:0] en_eff;
    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] empty;
    logic [N_OUT-1:0] push;
    logic [N_OUT-1:0] pop;
    logic             accept;

    // Handshakes: a beat moves on a port in any cycle where its valid and ready
    // are both high at the rising edge; valid never waits on ready, and din_ready
    // is derived only from registered FIFO state and the mask, never from dout_ready.
    assign en_eff    = (state == FRAME) ? mask_q : dout_en;
    assign din_ready = &(~en_eff | ~full);
    assign accept    = din_valid & din_ready;
    assign busy      = (state == FRAME) | ~(&empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mask_q <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    mask_q <= dout_en;
                    state  <= din_eot[1] ? IDLE : FRAME;
                end
                FRAME: begin
                    if (din_eot[1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        logic [W_DATA+1:0] mem [DEPTH];
        logic [AW:0]       wr_ptr;
        logic [AW:0]       rd_ptr;

        // Extra pointer MSB distinguishes full from empty when the low bits match.
        assign empty[i] = (wr_ptr == rd_ptr);
        assign full[i]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign push[i]  = accept & en_eff[i];
        assign pop[i]   = ~empty[i] & dout_ready[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop[i])  rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push[i]) mem[wr_ptr[AW-1:0]] <= {din_eot, din_data};
        end

        assign dout_valid[i] = ~empty[i];
        assign {dout_eot[2*i +: 2], dout_data[i*W_DATA +: W_DATA]} = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: tb/tb_broadcast_n.sv
// Directed bench for broadcast_n: scoreboard queues per output, fed from observed
// input accepts through a small frame/mask model and drained by observed output pops.
module tb_broadcast_n;

    localparam int W_DATA = 8;
    localparam int N_OUT  = 4;
    localparam int DEPTH  = 4;

    logic                    clk;
    logic                    rst;
    logic                    din_valid;
    logic                    din_ready;
    logic [W_DATA-1:0]       din_data;
    logic [1:0]              din_eot;
    logic [N_OUT-1:0]        dout_en;
    logic [N_OUT-1:0]        dout_valid;
    logic [N_OUT-1:0]        dout_ready;
    logic [N_OUT*W_DATA-1:0] dout_data;
    logic [2*N_OUT-1:0]      dout_eot;
    logic                    busy;

    broadcast_n #(.W_DATA(W_DATA), .N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .din_eot    (din_eot),
        .dout_en    (dout_en),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_eot   (dout_eot),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic rand_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // scoreboard: expected {eot, data} per output
    logic [W_DATA+1:0] exp_q [N_OUT][$];
    logic              m_in_frame;
    logic [N_OUT-1:0]  m_mask;

    function automatic int q_total();
        int t = 0;
        for (int i = 0; i < N_OUT; i++) t += exp_q[i].size();
        return t;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) exp_q[i].delete();
            m_in_frame = 1'b0;
            m_mask     = '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (dout_valid[i] && dout_ready[i]) begin
                    logic [W_DATA+1:0] got;
                    got = {dout_eot[2*i +: 2], dout_data[i*W_DATA +: W_DATA]};
                    check($sformatf("pop_expected_o%0d", i), {31'b0, exp_q[i].size() != 0}, 32'd1);
                    if (exp_q[i].size() != 0)
                        check($sformatf("out_beat_o%0d", i), {22'b0, got}, {22'b0, exp_q[i].pop_front()});
                end
            end
            if (din_valid && din_ready) begin
                logic [N_OUT-1:0] eff;
                eff = m_in_frame ? m_mask : dout_en;
                if (!m_in_frame) m_mask = dout_en;
                m_in_frame = !din_eot[1];
                for (int i = 0; i < N_OUT; i++) begin
                    if (eff[i]) begin
                        exp_q[i].push_back({din_eot, din_data});
                        check($sformatf("occupancy_o%0d", i), {31'b0, exp_q[i].size() <= DEPTH}, 32'd1);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            dout_ready = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
            dout_en    = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
        end
    endtask

    task automatic send_beat(input logic [W_DATA-1:0] d, input logic [1:0] e);
        logic acc = 1'b0;
        din_valid = 1'b1;
        din_data  = d;
        din_eot   = e;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = din_ready;
            step();
        end
        check("accept_in_time", {31'b0, acc}, 32'd1);
    endtask

    task automatic drain(input string tag);
        rand_mode  = 1'b0;
        din_valid  = 1'b0;
        dout_ready = '1;
        for (int c = 0; c < 60 && q_total() != 0; c++) step();
        check({"drain_", tag}, q_total(), 32'd0);
        @(negedge clk);
        check({"idle_valid_", tag}, {28'b0, dout_valid}, 32'd0);
        check({"idle_busy_", tag}, {31'b0, busy}, 32'd0);
        step();
    endtask

    initial begin
        int acc_n;
        logic acc;
        logic [W_DATA-1:0] b;

        rst = 1'b1; din_valid = 1'b0; din_data = '0; din_eot = '0;
        dout_en = '0; dout_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {28'b0, dout_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, din_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // pass-through
        dout_en = 4'b1111; dout_ready = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            din_valid = 1'b1;
            din_data  = W_DATA'(k);
            din_eot   = (k == 8) ? 2'b10 : ((k % 4 == 0) ? 2'b01 : 2'b00);
            @(negedge clk);
            check("t1_ready", {31'b0, din_ready}, 32'd1);
            if (k > 1) check("t1_latency", {28'b0, dout_valid}, 32'hF);
            step();
        end
        din_valid = 1'b0;
        @(negedge clk);
        check("t1_last_valid", {28'b0, dout_valid}, 32'hF);
        check("t1_last_data", {24'b0, dout_data[3*W_DATA +: W_DATA]}, 32'h08);
        check("t1_last_eot", {30'b0, dout_eot[7:6]}, 32'h2);
        step();
        @(negedge clk);
        check("t1_busy_end", {31'b0, busy}, 32'd0);
        step();

        // stalled output 2
        dout_ready = 4'b1011;
        b = 8'd1;
        din_valid = 1'b1; din_data = b; din_eot = 2'b00;
        acc_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = din_ready;
            check(c < 4 ? "stall_ready_hi" : "stall_ready_lo", {31'b0, din_ready}, c < 4 ? 32'd1 : 32'd0);
            step();
            if (acc) begin
                acc_n++;
                b = b + 8'd1;
                din_data = b;
                din_eot  = (b == 8'd6) ? 2'b10 : 2'b00;
            end
        end
        check("stall_count", acc_n, 32'd4);
        dout_ready = 4'b1111;
        @(negedge clk);
        check("stall_no_bypass", {31'b0, din_ready}, 32'd0);
        step();
        @(negedge clk);
        check("stall_resume", {31'b0, din_ready}, 32'd1);
        step();
        send_beat(8'd6, 2'b10);
        drain("stall");

        // mask latching
        dout_en = 4'b0101;
        send_beat(8'h11, 2'b00);
        din_valid = 1'b0;
        dout_en = 4'b1010;
        @(negedge clk);
        check("mask_first_valid", {28'b0, dout_valid}, 32'h5);
        step();
        send_beat(8'h12, 2'b01);
        send_beat(8'h13, 2'b00);
        send_beat(8'h14, 2'b10);
        send_beat(8'h21, 2'b00);
        din_valid = 1'b0;
        @(negedge clk);
        check("mask_second_valid", {28'b0, dout_valid}, 32'hA);
        step();
        send_beat(8'h22, 2'b00);
        send_beat(8'h23, 2'b10);
        drain("mask");

        // all-zero mask
        dout_en = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            din_valid = 1'b1;
            din_data  = W_DATA'(8'h30 + k);
            din_eot   = (k == 6) ? 2'b10 : 2'b00;
            @(negedge clk);
            check("zero_ready", {31'b0, din_ready}, 32'd1);
            check("zero_valid", {28'b0, dout_valid}, 32'd0);
            check("zero_busy", {31'b0, busy}, (k > 1) ? 32'd1 : 32'd0);
            step();
        end
        din_valid = 1'b0;
        @(negedge clk);
        check("zero_busy_end", {31'b0, busy}, 32'd0);
        step();

        // random ready and mask, 1000 beats
        rand_mode = 1'b1;
        for (int k = 0; k < 1000; k++)
            send_beat(W_DATA'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        send_beat(8'hEE, 2'b10);
        drain("random");

        // reset with FIFOs half full, mid-frame
        dout_ready = 4'b0000; dout_en = 4'b1111;
        send_beat(8'hA1, 2'b00);
        send_beat(8'hA2, 2'b00);
        din_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", {28'b0, dout_valid}, 32'hF);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {28'b0, dout_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_ready", {31'b0, din_ready}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        dout_ready = 4'b1111; dout_en = 4'b0010;
        send_beat(8'hB1, 2'b10);
        din_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {28'b0, dout_valid}, 32'h2);
        step();
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/broadcast_n.md
# broadcast_n

Parametrised N-way stream broadcaster with a per-output FIFO and a per-frame output-enable mask. Each accepted input beat (data + 2-bit eot) is copied into the FIFO of every enabled output; the outputs drain independently, so one slow consumer only stalls the producer once its FIFO is full. The block sits between the window/feature stages and their parallel consumers, replacing the two-output, unbuffered broadcaster. `din_ready` has no combinational dependence on any `dout_ready`.

## Interface
- `W_DATA`, 8, data width per beat.
- `N_OUT`, 4, number of output streams; must be ≥ 2.
- `DEPTH`, 4, entries per output FIFO; power of two, ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `din_valid` input 1: input beat valid.
- `din_ready` output 1: input beat accepted when `din_valid` and `din_ready` are both high.
- `din_data` input W_DATA: input data.
- `din_eot` input 2: bit0 = end of row; bit1 = end of frame.
- `dout_en` input N_OUT: output-enable mask, sampled on the first beat of each frame.
- `dout_valid` output N_OUT: per-output valid.
- `dout_ready` input N_OUT: per-output ready.
- `dout_data` output N_OUT*W_DATA: output i occupies bits [i*W_DATA +: W_DATA].
- `dout_eot` output 2*N_OUT: output i occupies bits [2*i +: 2].
- `busy` output 1: high while in a frame or while any FIFO is non-empty.

## Operation
- Frame FSM, two states:
  - **IDLE**: between frames.
    - On accept: `mask_q <= dout_en`.
    - Next state: FRAME unless `din_eot[1]` is set, in which case stay in IDLE (single-beat frame).
  - **FRAME**: on an accept with `din_eot[1]` set, go to IDLE.
- Effective mask `en_eff`:
  - In IDLE: `en_eff = dout_en` (live input).
  - In FRAME: `en_eff = mask_q`.
  - Changes to `dout_en` mid-frame are ignored.
- `din_ready` = AND over i of (!`en_eff[i]` | !`full[i]`).
- Accept = `din_valid & din_ready`. On accept, {`din_eot`, `din_data`} is written into every FIFO i with `en_eff[i]` = 1. Disabled outputs receive nothing.
- All-zero mask: beats are accepted every cycle and discarded. The FSM still tracks frame boundaries.
- Per-output FIFO:
  - Register array with log2(DEPTH)+1-bit read and write pointers; the MSB differs when full.
  - `empty` when the pointers are equal; `full` when the low bits are equal and the MSBs differ.
  - `dout_valid[i]` = !`empty[i]`. Data and eot come combinationally from the head entry.
  - Pop on `dout_valid[i] & dout_ready[i]`.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: occupancy is unchanged.
  - No write bypass when full: a full FIFO blocks `din_ready` even if it pops in the same cycle.
- Pointers wrap modulo 2·DEPTH. Order within each output is strictly preserved.
- `busy` = (state == FRAME) | (OR over i of !`empty[i]`).

## Timing
- Reset (asynchronous assert):
  - State = IDLE; `mask_q` = 0; all pointers = 0.
  - `dout_valid` = 0; `busy` = 0.
  - `din_ready` = 1 (all FIFOs empty).
  - FIFO data contents are don't-care.
- Reset deassertion is synchronised externally. Reset mid-frame discards all buffered beats and returns to IDLE.
- Latency: a beat accepted at edge k is visible on `dout_valid[i]` after edge k.
- Throughput: 1 beat/cycle when all enabled consumers hold ready high.
- Backpressure: with output i stalled, exactly DEPTH further beats are accepted; `din_ready` drops in the cycle after the DEPTH-th accept.
- `din_ready` depends only on registered state and `dout_en` (in IDLE). It has no path from `dout_ready` or `din_valid`.

## Test plan
- **Reset and pass-through.** Reset, then mask=4'b1111, all ready=1, stream 0x01..0x08 with eot[1] on 0x08.
  - All four outputs carry 0x01..0x08, each 1 cycle after accept.
  - `din_ready` stays 1; eot matches per beat.
- **Stalled output.** N_OUT=4, DEPTH=4, `dout_ready[2]`=0, others 1, continuous valid.
  - Exactly 4 beats are accepted, then `din_ready`=0.
  - Raising `dout_ready[2]` drains 0x01..0x04 in order, and input resumes the following cycle.
- **Mask latching.** Frame 1 uses mask 4'b0101; toggle `dout_en` to 4'b1010 mid-frame.
  - Outputs 0 and 2 only receive all frame-1 beats.
  - Frame 2 (mask 4'b1010, sampled on its first beat) goes only to outputs 1 and 3.
- **All-zero mask.** Mask 0, 6-beat frame.
  - All beats are accepted back-to-back; no `dout_valid` rises.
  - `busy` is 1 during the frame and 0 after the eot[1] beat.
- **Wrap-around, simultaneous push/pop, and reset mid-operation.**
  - Random ready per output for 1000 beats: each output sequence equals the input sequence for its mask, and FIFO occupancy never exceeds DEPTH.
  - Assert `rst` with FIFOs half full: all `dout_valid` drop to 0 immediately; FSM in IDLE.
